// File: rtl/serial_cmd_pkg.sv
// Shared constants and state encoding for the serial command decoder.
package serial_cmd_pkg;

  localparam int unsigned HDR_BITS   = 8;
  localparam int unsigned FRAME_BITS = 40;
  localparam int unsigned RW_BIT     = 7;
  localparam int unsigned CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    WDATA,
    RDATA
  } state_t;

endpackage

// File: rtl/serial_edge_sync.sv
// Multi-stage synchronizer for an asynchronous serial pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
module serial_edge_sync
  import serial_cmd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic master_clk,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   sync_lvl;

  // Synchronizer chain followed by the edge-detect register. Clearing to 0
  // means a pin already low when reset releases never produces a fall pulse.
  always_ff @(posedge master_clk) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign rise     = sync_lvl & ~edge_q;
  assign fall     = ~sync_lvl & edge_q;

endmodule

// File: rtl/serial_cmd_decoder.sv
// Serial control bus front-end: decodes SEN/SCLK/SDI frames into the parallel
// write bus and services readback frames onto SDO.
module serial_cmd_decoder
  import serial_cmd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              master_clk,
  input  logic              reset,
  input  logic              serial_enable_n,
  input  logic              serial_clock,
  input  logic              serial_data_in,
  output logic              serial_data_out,
  output logic              serial_data_oe,
  output logic [ADDR_W-1:0] serial_addr,
  output logic [DATA_W-1:0] serial_data,
  output logic              serial_strobe,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_req,
  input  logic [DATA_W-1:0] rd_data,
  output logic              frame_error
);

  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0] HDR_CNT  = CNT_W'(HDR_BITS);
  localparam logic [CNT_W-1:0] WR_CNT   = CNT_W'(FRAME_BITS);

  logic                   sen_rise;
  logic                   sen_fall;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic [SYNC_STAGES-1:0] sdi_q;
  logic                   sdi_d;

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [CNT_W-1:0]       cnt_inc;
  logic [HDR_BITS-2:0]    hdr_sr;
  logic [HDR_BITS-1:0]    hdr_next;
  logic [DATA_W-1:0]      data_sr;
  logic [DATA_W-1:0]      out_sr;
  logic                   load_now;

  serial_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sen_sync (
    .master_clk (master_clk),
    .reset      (reset),
    .async_in   (serial_enable_n),
    .rise       (sen_rise),
    .fall       (sen_fall)
  );

  serial_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .master_clk (master_clk),
    .reset      (reset),
    .async_in   (serial_clock),
    .rise       (sclk_rise),
    .fall       (sclk_fall)
  );

  // SDI delay line, same depth as the synchronizers so it stays aligned with SCLK.
  always_ff @(posedge master_clk) begin
    if (reset) begin
      sdi_q <= '0;
    end else begin
      sdi_q <= {sdi_q[SYNC_STAGES-2:0], serial_data_in};
    end
  end

  assign sdi_d = sdi_q[SYNC_STAGES-1];

  // Header view including the bit arriving this cycle; the R/W bit is only
  // needed at the moment the header completes, so it is never stored.
  always_comb begin
    hdr_next = {hdr_sr, sdi_d};
    cnt_inc  = (bit_cnt == '1) ? bit_cnt : bit_cnt + 1'b1;
  end

  assign serial_data_out = out_sr[DATA_W-1];

  // Frame FSM with registered write bus, readback request and SDO shifter.
  always_ff @(posedge master_clk) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      hdr_sr         <= '0;
      data_sr        <= '0;
      out_sr         <= '0;
      load_now       <= 1'b0;
      serial_addr    <= '0;
      serial_data    <= '0;
      serial_strobe  <= 1'b0;
      rd_req         <= 1'b0;
      rd_addr        <= '0;
      frame_error    <= 1'b0;
      serial_data_oe <= 1'b0;
    end else begin
      serial_strobe <= 1'b0;
      rd_req        <= 1'b0;
      frame_error   <= 1'b0;
      load_now      <= rd_req;

      case (state)
        IDLE: begin
          if (sen_fall) begin
            state   <= HEADER;
            bit_cnt <= '0;
          end
        end

        HEADER: begin
          if (sen_rise) begin
            frame_error <= 1'b1;
            state       <= IDLE;
          end else if (sclk_rise) begin
            hdr_sr  <= hdr_next[HDR_BITS-2:0];
            bit_cnt <= cnt_inc;
            if (bit_cnt == HDR_LAST) begin
              if (hdr_next[RW_BIT]) begin
                state   <= RDATA;
                rd_req  <= 1'b1;
                rd_addr <= hdr_next[ADDR_W-1:0];
              end else begin
                state <= WDATA;
              end
            end
          end
        end

        WDATA: begin
          if (sen_rise) begin
            state <= IDLE;
            if (bit_cnt == WR_CNT) begin
              serial_strobe <= 1'b1;
              serial_addr   <= hdr_sr[ADDR_W-1:0];
              serial_data   <= data_sr;
            end else begin
              frame_error <= 1'b1;
            end
          end else if (sclk_rise) begin
            data_sr <= {data_sr[DATA_W-2:0], sdi_d};
            bit_cnt <= cnt_inc;
          end
        end

        RDATA: begin
          if (sen_rise) begin
            state          <= IDLE;
            serial_data_oe <= 1'b0;
            out_sr         <= '0;
          end else begin
            if (sclk_rise) begin
              bit_cnt <= cnt_inc;
            end
            // The falling edge that closes the last header bit must not shift:
            // the MSB has to stay on SDO until the master samples it on the
            // next rising edge.
            if (load_now) begin
              out_sr         <= rd_data;
              serial_data_oe <= 1'b1;
            end else if (sclk_fall && (bit_cnt > HDR_CNT)) begin
              out_sr <= {out_sr[DATA_W-2:0], 1'b0};
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmd_decoder.sv
// Self-checking bench for serial_cmd_decoder: table of directed frames,
// hand-written reset/back-to-back sequences, and random frames checked
// against a frame-level outcome model.
module tb_serial_cmd_decoder;

  localparam int H = 6;  // master clocks per SCLK half period

  logic        master_clk = 1'b0;
  logic        reset;
  logic        sen;
  logic        sclk;
  logic        sdi;
  logic        sdo;
  logic        oe;
  logic [6:0]  s_addr;
  logic [31:0] s_data;
  logic        strobe;
  logic [6:0]  rd_addr;
  logic        rd_req;
  logic [31:0] rd_data;
  logic        ferr;

  always #5 master_clk = ~master_clk;

  serial_cmd_decoder #(
    .SYNC_STAGES (2),
    .ADDR_W      (7),
    .DATA_W      (32)
  ) dut (
    .master_clk      (master_clk),
    .reset           (reset),
    .serial_enable_n (sen),
    .serial_clock    (sclk),
    .serial_data_in  (sdi),
    .serial_data_out (sdo),
    .serial_data_oe  (oe),
    .serial_addr     (s_addr),
    .serial_data     (s_data),
    .serial_strobe   (strobe),
    .rd_addr         (rd_addr),
    .rd_req          (rd_req),
    .rd_data         (rd_data),
    .frame_error     (ferr)
  );

  int total = 0;
  int bad   = 0;

  int          n_strobe = 0;
  int          n_err    = 0;
  int          n_rdreq  = 0;
  logic [6:0]  mon_rd_addr = '0;
  logic [31:0] rd_val = '0;
  logic [6:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;

  typedef struct {
    string       name;
    logic [7:0]  hdr;
    logic [31:0] data;
    int          nbits;
    logic [31:0] rval;
    bit          sim_end;
    bit          exp_strb;
    bit          exp_err;
    bit          exp_rd;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge master_clk);
  endtask

  // Pulse and readback-request monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge master_clk);
      if (strobe === 1'b1) n_strobe++;
      if (ferr === 1'b1) n_err++;
      if (rd_req === 1'b1) begin
        n_rdreq++;
        mon_rd_addr = rd_addr;
      end
    end
  end

  // Readback source: word is valid only during the cycle after rd_req.
  initial begin
    rd_data = 32'hFFFF_FFFF;
    forever begin
      @(negedge master_clk);
      if (rd_req === 1'b1) begin
        @(negedge master_clk);
        rd_data = rd_val;
        @(negedge master_clk);
        rd_data = $urandom;
      end
    end
  end

  // Time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // Frame-level outcome from the frame rules; an SCLK edge coinciding with
  // the SEN rise is not counted.
  function automatic void predict(input logic [7:0] hdr, input int nbits, input bit sim_end,
                                  output bit strb, output bit err, output bit rd);
    int eff;
    eff  = sim_end ? nbits - 1 : nbits;
    strb = 1'b0;
    err  = 1'b0;
    rd   = 1'b0;
    if (eff < 8) err = 1'b1;
    else if (hdr[7]) rd = 1'b1;
    else if (eff == 40) strb = 1'b1;
    else err = 1'b1;
  endfunction

  task automatic clock_bit(input logic b);
    sdi = b;
    wait_cyc(H);
    sclk = 1'b1;
    wait_cyc(H);
    sclk = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic [7:0] hdr, input logic [31:0] data,
                           input int nbits, input logic [31:0] rval, input bit sim_end,
                           input int gap, input bit e_strb, input bit e_err, input bit e_rd);
    int          s0, e0, r0;
    logic [39:0] bits;
    logic        want_sdo;
    bits   = {hdr, data};
    s0     = n_strobe;
    e0     = n_err;
    r0     = n_rdreq;
    rd_val = rval;
    sen    = 1'b0;
    wait_cyc(H);
    for (int i = 0; i < nbits; i++) begin
      sdi = (i < 40) ? bits[39-i] : 1'($urandom);
      wait_cyc(H);
      if (i == 7) check({name, " oe_hdr"}, 64'(oe), 64'(0));
      if (hdr[7] && i >= 8) begin
        want_sdo = rval[39-i];
        check($sformatf("%s sdo[%0d]", name, i - 8), 64'(sdo), 64'(want_sdo));
        check($sformatf("%s oe[%0d]", name, i - 8), 64'(oe), 64'(1));
      end
      if (sim_end && i == nbits - 1) begin
        sclk = 1'b1;
        sen  = 1'b1;
      end else begin
        sclk = 1'b1;
        wait_cyc(H);
        sclk = 1'b0;
      end
    end
    if (!sim_end) begin
      wait_cyc(H);
      sen = 1'b1;
    end
    wait_cyc(H);
    sclk = 1'b0;
    wait_cyc(8);
    if (e_strb) begin
      exp_addr = hdr[6:0];
      exp_data = data;
    end
    check({name, " strobes"}, 64'(n_strobe - s0), 64'(e_strb));
    check({name, " errors"}, 64'(n_err - e0), 64'(e_err));
    check({name, " rd_reqs"}, 64'(n_rdreq - r0), 64'(e_rd));
    check({name, " addr"}, 64'(s_addr), 64'(exp_addr));
    check({name, " data"}, 64'(s_data), 64'(exp_data));
    check({name, " oe_end"}, 64'(oe), 64'(0));
    if (e_rd) check({name, " rd_addr"}, 64'(mon_rd_addr), 64'(hdr[6:0]));
    wait_cyc(gap);
  endtask

  initial begin
    bit          ps, pe, pr;
    int          s0, e0;
    logic [39:0] rbits;
    logic [7:0]  hdr;
    logic [31:0] dat;
    int          nb;
    int          kind;
    bit          se;

    tbl[0] = '{"wr40",      8'h05, 32'hDEADBEEF, 40, '0,           1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{"wr39",      8'h05, 32'h11111111, 39, '0,           1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{"wr41",      8'h05, 32'h22222222, 41, '0,           1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{"rd92",      8'h92, 32'h0,        40, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{"hdr_abort", 8'h05, 32'h0,         5, '0,           1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{"wr33",      8'h33, 32'hCAFEF00D, 40, '0,           1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{"wr104_sat", 8'h44, 32'h0F0F0F0F,104, '0,           1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{"sen_wins",  8'h06, 32'h0BADF00D, 41, '0,           1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{"rd_hdr8",   8'hFF, 32'h0,         8, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{"wr_hdr8",   8'h7F, 32'h0,         8, '0,           1'b0, 1'b0, 1'b1, 1'b0};

    reset = 1'b1;
    sen   = 1'b1;
    sclk  = 1'b0;
    sdi   = 1'b0;
    wait_cyc(4);
    check("reset outputs", {s_addr, s_data, strobe, rd_addr, rd_req, ferr, sdo, oe}, '0);
    reset = 1'b0;
    wait_cyc(10);

    foreach (tbl[k])
      run_frame(tbl[k].name, tbl[k].hdr, tbl[k].data, tbl[k].nbits, tbl[k].rval,
                tbl[k].sim_end, 20, tbl[k].exp_strb, tbl[k].exp_err, tbl[k].exp_rd);

    // Reset in the middle of a write; the remainder of that frame is ignored.
    s0    = n_strobe;
    e0    = n_err;
    rbits = {8'h05, 32'hA5A5A5A5};
    sen   = 1'b0;
    wait_cyc(H);
    for (int i = 0; i < 20; i++) clock_bit(rbits[39-i]);
    reset = 1'b1;
    wait_cyc(3);
    check("midreset outputs", {s_addr, s_data, strobe, rd_addr, rd_req, ferr, sdo, oe}, '0);
    reset = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    for (int i = 20; i < 40; i++) clock_bit(rbits[39-i]);
    wait_cyc(H);
    sen = 1'b1;
    wait_cyc(12);
    check("midreset strobes", 64'(n_strobe - s0), 64'(0));
    check("midreset errors", 64'(n_err - e0), 64'(0));
    check("midreset addr", 64'(s_addr), 64'(0));
    wait_cyc(20);
    run_frame("post_reset", 8'h7F, 32'h00000001, 40, '0, 1'b0, 20, 1'b1, 1'b0, 1'b0);

    // Back-to-back writes separated by two SCLK periods of SEN high.
    run_frame("b2b_1", 8'h01, 32'hAAAA5555, 40, '0, 1'b0, 4 * H - 8 - H, 1'b1, 1'b0, 1'b0);
    run_frame("b2b_2", 8'h02, 32'h5555AAAA, 40, '0, 1'b0, 20, 1'b1, 1'b0, 1'b0);

    // Random frames against the outcome model.
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 5);
      dat  = $urandom;
      se   = 1'b0;
      hdr  = {1'b0, 7'($urandom)};
      case (kind)
        0: nb = 40;
        1: nb = $urandom_range(8, 50);
        2: begin hdr[7] = 1'b1; nb = $urandom_range(8, 40); end
        3: begin hdr[7] = 1'($urandom); nb = $urandom_range(1, 7); end
        4: begin nb = $urandom_range(40, 41); se = 1'b1; end
        default: begin hdr[7] = 1'b1; nb = $urandom_range(9, 40); se = 1'b1; end
      endcase
      predict(hdr, nb, se, ps, pe, pr);
      run_frame($sformatf("rnd%0d", t), hdr, dat, nb, $urandom, se, 20, ps, pe, pr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
